board_clock_report_uart: RTL and testbench
==========================================

# board_clock_report_uart

Serializes frequency-checkout results onto a UART TX line as one ASCII hex line per snapshot. Sits directly downstream of the per-clock counters in the board checkout top level. On each snapshot strobe (normally the per-interval flag derived from the `sysclk` millisecond tick) it latches every channel's count and prints it. A bench terminal can then read all clock frequencies without JTAG.

## Interface
Parameters:
- `NUM_CH`, 3, number of count channels (1..16).
- `CNT_WIDTH`, 16, bits per count; must be a multiple of 4.
- `BAUD_DIV`, 564, `clk` cycles per UART bit (65 MHz / 115200); must be ≥ 2.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock (`sysclk`).
- `rst`  in  1  asynchronous active-high reset.
- `snap_i`  in  1  single-cycle snapshot request.
- `count_i`  in  NUM_CH*CNT_WIDTH  channel counts; channel k occupies `[k*CNT_WIDTH +: CNT_WIDTH]`.
- `tx_o`  out  1  UART TX, 8N1, idle high.
- `busy_o`  out  1  high while a line is being latched or sent.
- `overrun_o`  out  1  sticky: a snapshot was dropped because `busy_o` was high.

## Operation
- Line format, per channel k = 0..NUM_CH-1 in order:
  - one uppercase hex digit of k;
  - `:`;
  - CNT_WIDTH/4 uppercase hex digits, MSB nibble first.
  - Channels are separated by a single space (0x20); the line ends with CR (0x0D) and LF (0x0A).
- Line length L = NUM_CH*(2+CNT_WIDTH/4) + (NUM_CH-1) + 2.
  - Example: NUM_CH=2, CNT_WIDTH=16 gives L=15.
- Shadow register: all of `count_i` is copied at acceptance, so later changes to `count_i` do not affect the line in flight.
- States:
  - IDLE → FETCH on accepted snap.
  - FETCH: select the next character (1 cycle) → START.
  - START: `tx_o`=0 for BAUD_DIV cycles → DATA.
  - DATA: 8 bits, LSB first, each held BAUD_DIV cycles → STOP.
  - STOP: `tx_o`=1 for BAUD_DIV cycles → FETCH if characters remain, else IDLE.
- Character index counts 0..L-1. Digits are converted as 0–9 → 0x30–0x39 and A–F → 0x41–0x46.
- Acceptance: a snapshot is accepted when `snap_i`=1 is sampled with registered `busy_o`=0.
- Dropped snapshot: `snap_i`=1 sampled with `busy_o`=1 sets `overrun_o`. The flag stays set until `rst`; the line in flight is unaffected.

## Timing
- Reset values: `tx_o`=1, `busy_o`=0, `overrun_o`=0, shadow register all 0, state IDLE, character index 0.
- Reset mid-line: `tx_o` returns high asynchronously and the partial character is abandoned. After reset release nothing is sent until a new `snap_i`.
- Snap accepted at edge N:
  - Shadow loads and `busy_o`=1 after edge N.
  - FETCH occupies cycle N+1.
  - `tx_o` falls after edge N+2.
- Inter-character gap: each STOP is followed by a 1-cycle FETCH, so the character period is 10*BAUD_DIV+1 cycles. The stop bit is therefore high for BAUD_DIV+1 cycles on every character except the last.
- End of line: after the last character's stop bit, `busy_o` falls on the same edge the state returns to IDLE.
  - Total busy time = 1 + L*(10*BAUD_DIV+1) cycles.
- Snap on the edge where `busy_o` falls: it is still sampled against `busy_o`=1, so it is dropped and counted as overrun.
- Back-to-back: a snap on the first cycle with `busy_o`=0 is accepted normally.
- Bit-period counter: wraps from BAUD_DIV-1 to 0. It needs a width of at least clog2(BAUD_DIV).

## Test plan
- Reset check: assert `rst` with no snap → `tx_o`=1, `busy_o`=0, `overrun_o`=0 held for 10000 cycles.
- Basic line (NUM_CH=2, CNT_WIDTH=16, BAUD_DIV=4):
  - Stimulus: `count_i`=0xABCD_1234, one-cycle `snap_i`.
  - Required: the decoded line is "0:1234 1:ABCD\r\n" (15 bytes).
  - Required: `tx_o` falls exactly 2 cycles after the snap edge.
  - Required: `busy_o` stays high for 1+15*41=616 cycles.
- Shadow stability: change `count_i` to 0xFFFF_0000 one cycle after the snap → the line still reads "0:1234 1:ABCD\r\n".
- Overrun:
  - Second snap mid-line → the line is unchanged, `overrun_o`=1 and stays 1 after the line ends.
  - Snap on the edge where `busy_o` falls → also overrun.
  - Snap one cycle later → a new line starts.
- Reset mid-line: assert `rst` during the DATA bits of the 5th character → `tx_o`=1 immediately and `busy_o`=0. After release plus a new snap, a complete correct line is sent from character 0.
- Boundary (NUM_CH=16, CNT_WIDTH=4, BAUD_DIV=2):
  - Stimulus: counts 0x0..0xF.
  - Required: the line is "0:0 1:1 … F:F\r\n" with L=65.
  - Required: every bit period is exactly 2 cycles, and every stop bit is 3 cycles except the last, which is 2.

Source files
------------

// File: rtl/board_clock_report_uart.sv
// rtl/board_clock_report_uart.sv - prints latched clock counts as one ASCII hex line per snapshot on a UART TX line
module board_clock_report_uart #(
    parameter int NUM_CH    = 3,
    parameter int CNT_WIDTH = 16,
    parameter int BAUD_DIV  = 564
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          snap_i,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   count_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic                          overrun_o
);

    localparam int DIGITS = CNT_WIDTH / 4;
    localparam int POS_W  = $clog2(DIGITS + 4);
    localparam int BAUD_W = $clog2(BAUD_DIV);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [3:0]        CH_LAST   = 4'(NUM_CH - 1);
    localparam logic [POS_W-1:0]  POS_SEP   = POS_W'(DIGITS + 2);
    localparam logic [POS_W-1:0]  POS_LF    = POS_W'(DIGITS + 3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                        state;
    state_t                        state_next;
    logic [NUM_CH*CNT_WIDTH-1:0]   shadow;
    logic [3:0]                    ch;
    logic [POS_W-1:0]              pos;
    logic [7:0]                    char_reg;
    logic                          last_char;
    logic [BAUD_W-1:0]             baud_cnt;
    logic [2:0]                    bit_idx;
    logic                          baud_end;
    logic                          tx_next;
    logic [CNT_WIDTH-1:0]          ch_val;
    logic [3:0]                    nib;
    logic [7:0]                    hex_char;
    logic [7:0]                    char_sel;
    logic                          is_last;

    assign baud_end = (baud_cnt == BAUD_LAST);

    // Character generator: (channel, position-in-channel) picks the next ASCII byte of the line
    always_comb begin
        ch_val   = '0;
        nib      = ch;
        char_sel = 8'h3F;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch == 4'(k)) begin
                ch_val = shadow[k*CNT_WIDTH +: CNT_WIDTH];
            end
        end
        for (int j = 0; j < DIGITS; j++) begin
            if (pos == POS_W'(j + 2)) begin
                nib = ch_val[(DIGITS-1-j)*4 +: 4];
            end
        end
        hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        if (pos == POS_W'(1)) begin
            char_sel = 8'h3A;
        end else if (pos == POS_SEP) begin
            char_sel = (ch == CH_LAST) ? 8'h0D : 8'h20;
        end else if (pos == POS_LF) begin
            char_sel = 8'h0A;
        end else begin
            char_sel = hex_char;
        end
        is_last = (ch == CH_LAST) && (pos == POS_LF);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and next TX level; IDLE with busy set is the one-cycle latch step before FETCH
    always_comb begin
        state_next = state;
        tx_next    = 1'b1;
        case (state)
            S_IDLE: begin
                if (busy_o) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_START;
                tx_next    = 1'b0;
            end
            S_START: begin
                tx_next = 1'b0;
                if (baud_end) begin
                    state_next = S_DATA;
                    tx_next    = char_reg[0];
                end
            end
            S_DATA: begin
                tx_next = char_reg[bit_idx];
                if (baud_end) begin
                    if (bit_idx == 3'd7) begin
                        state_next = S_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        tx_next = char_reg[3'(bit_idx + 3'd1)];
                    end
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    state_next = last_char ? S_IDLE : S_FETCH;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: snapshot acceptance, character stepping, bit timing and the registered TX line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_o      <= 1'b1;
            busy_o    <= 1'b0;
            overrun_o <= 1'b0;
            shadow    <= '0;
            ch        <= '0;
            pos       <= '0;
            char_reg  <= '0;
            last_char <= 1'b0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
        end else begin
            tx_o <= tx_next;
            if (snap_i) begin
                if (busy_o) begin
                    overrun_o <= 1'b1;
                end else begin
                    shadow <= count_i;
                    busy_o <= 1'b1;
                    ch     <= '0;
                    pos    <= '0;
                end
            end
            if (state == S_FETCH) begin
                char_reg  <= char_sel;
                last_char <= is_last;
                if (pos == POS_SEP && ch != CH_LAST) begin
                    ch  <= ch + 4'd1;
                    pos <= '0;
                end else begin
                    pos <= pos + POS_W'(1);
                end
            end
            if (state == S_START || state == S_DATA || state == S_STOP) begin
                baud_cnt <= baud_end ? '0 : baud_cnt + BAUD_W'(1);
            end else begin
                baud_cnt <= '0;
            end
            if (state == S_DATA) begin
                if (baud_end) begin
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                bit_idx <= '0;
            end
            // The end-of-line clear wins over a same-edge snap, which was already counted as overrun
            if (state == S_STOP && baud_end && last_char) begin
                busy_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_board_clock_report_uart.sv
// tb/tb_board_clock_report_uart.sv - scoreboard bench for board_clock_report_uart in two configurations
module tb_board_clock_report_uart;

    logic        clk = 1'b0;
    logic        rst;
    logic        snap_a, snap_b;
    logic [31:0] count_a;
    logic [63:0] count_b;
    logic        tx_a, busy_a, ovr_a;
    logic        tx_b, busy_b, ovr_b;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];
    logic        smp[$];

    always #5 clk = ~clk;

    board_clock_report_uart #(.NUM_CH(2), .CNT_WIDTH(16), .BAUD_DIV(4)) dut_a (
        .clk(clk), .rst(rst), .snap_i(snap_a), .count_i(count_a),
        .tx_o(tx_a), .busy_o(busy_a), .overrun_o(ovr_a)
    );

    board_clock_report_uart #(.NUM_CH(16), .CNT_WIDTH(4), .BAUD_DIV(2)) dut_b (
        .clk(clk), .rst(rst), .snap_i(snap_b), .count_i(count_b),
        .tx_o(tx_b), .busy_o(busy_b), .overrun_o(ovr_b)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
    endfunction

    function automatic void push_line(input int nch, input int w, input logic [63:0] cnt);
        for (int k = 0; k < nch; k++) begin
            exp_q.push_back(hexc(4'(k)));
            exp_q.push_back(8'h3A);
            for (int d = w/4 - 1; d >= 0; d--) begin
                exp_q.push_back(hexc(cnt[k*w + d*4 +: 4]));
            end
            if (k < nch - 1) exp_q.push_back(8'h20);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    function automatic logic cur_tx(input int sel);
        return sel != 0 ? tx_b : tx_a;
    endfunction

    function automatic logic cur_busy(input int sel);
        return sel != 0 ? busy_b : busy_a;
    endfunction

    task automatic launch(input int sel);
        if (sel != 0) snap_b = 1'b1;
        else          snap_a = 1'b1;
    endtask

    // Records tx once per cycle (at negedge) while busy; optional mid-line snap, count change or reset
    task automatic capture(input int sel, input int snap_at, input int rst_at, input bit chg,
                           output int blen);
        bit done = 1'b0;
        smp.delete();
        blen = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            snap_a = 1'b0;
            snap_b = 1'b0;
            if (chg && blen == 0) count_a = 32'hFFFF_0000;
            if (!cur_busy(sel)) begin
                done = 1'b1;
                break;
            end
            smp.push_back(cur_tx(sel));
            blen++;
            if (blen - 1 == snap_at) launch(sel);
            if (blen - 1 == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_mid_tx", cur_tx(sel), 1);
                check("rst_mid_busy", cur_busy(sel), 0);
                done = 1'b1;
                break;
            end
        end
        if (!done) check("busy_timeout", 1, 0);
    endtask

    // Walks the per-cycle samples as 8N1 frames of b cycles per bit and scores each byte
    task automatic decode(input int b, input int nexp);
        int i = 0, idx = 0, run = 0, nch = 0, terr = 0;
        logic [7:0] byte_v, e;
        for (int c = 0; c < nexp; c++) begin
            while (i < smp.size() && smp[i] == 1'b1) i++;
            if (i >= smp.size()) break;
            if (c == 0) check("tx_fall_latency", i, 2);
            byte_v = '0;
            for (int k = 0; k < 10; k++) begin
                for (int j = 0; j < b; j++) begin
                    idx = i + k*b + j;
                    if (idx >= smp.size()) begin
                        terr++;
                    end else begin
                        if (k == 0 && smp[idx] !== 1'b0) terr++;
                        if (k == 9 && smp[idx] !== 1'b1) terr++;
                        if (smp[idx] !== smp[i + k*b]) terr++;
                        if (k >= 1 && k <= 8 && j == 0) byte_v[k-1] = smp[idx];
                    end
                end
            end
            run = 0;
            idx = i + 9*b;
            while (idx < smp.size() && smp[idx] == 1'b1) begin
                run++;
                idx++;
            end
            if (run != ((c == nexp - 1) ? b : b + 1)) terr++;
            if (exp_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("char%0d", c), byte_v, e);
            end
            nch++;
            i = idx;
        end
        check("line_chars", nch, nexp);
        check("bit_timing_errs", terr, 0);
        check("sb_left", exp_q.size(), 0);
    endtask

    initial begin
        int blen;
        int bad;
        rst = 1'b1; snap_a = 1'b0; snap_b = 1'b0;
        count_a = '0;
        count_b = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_ovr", ovr_a, 0);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || ovr_a !== 1'b0 ||
                tx_b !== 1'b1 || busy_b !== 1'b0 || ovr_b !== 1'b0) bad++;
        end
        check("idle_hold", bad, 0);

        // basic line
        count_a = 32'hABCD_1234;
        push_line(2, 16, {32'h0, count_a});
        launch(0);
        capture(0, -1, -1, 1'b0, blen);
        check("busy_len_basic", blen, 616);
        decode(4, 15);

        // shadow stability
        push_line(2, 16, {32'h0, count_a});
        launch(0);
        capture(0, -1, -1, 1'b1, blen);
        check("busy_len_shadow", blen, 616);
        decode(4, 15);
        check("ovr_clear", ovr_a, 0);

        // overrun mid-line
        count_a = 32'h5A5A_0F0F;
        push_line(2, 16, {32'h0, count_a});
        launch(0);
        capture(0, 300, -1, 1'b0, blen);
        check("busy_len_ovr", blen, 616);
        decode(4, 15);
        check("ovr_after_line", ovr_a, 1);
        repeat (5) @(negedge clk);
        check("ovr_sticky", ovr_a, 1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ovr_rst", ovr_a, 0);

        // snap on the falling edge of busy is dropped, the next cycle is accepted
        count_a = 32'h0123_89EF;
        push_line(2, 16, {32'h0, count_a});
        launch(0);
        capture(0, 615, -1, 1'b0, blen);
        check("busy_len_edge", blen, 616);
        decode(4, 15);
        check("ovr_edge", ovr_a, 1);
        count_a = 32'hC0DE_7E57;
        push_line(2, 16, {32'h0, count_a});
        launch(0);
        capture(0, -1, -1, 1'b0, blen);
        check("busy_len_b2b", blen, 616);
        decode(4, 15);

        // reset during the data bits of the 5th character
        count_a = 32'hFEDC_BA98;
        push_line(2, 16, {32'h0, count_a});
        launch(0);
        capture(0, -1, 185, 1'b0, blen);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        check("post_rst_idle", bad, 0);
        check("post_rst_ovr", ovr_a, 0);
        push_line(2, 16, {32'h0, count_a});
        launch(0);
        capture(0, -1, -1, 1'b0, blen);
        check("busy_len_post_rst", blen, 616);
        decode(4, 15);

        // boundary configuration: 16 channels, one digit each, two cycles per bit
        for (int k = 0; k < 16; k++) count_b[k*4 +: 4] = 4'(k);
        push_line(16, 4, count_b);
        launch(1);
        capture(1, -1, -1, 1'b0, blen);
        check("busy_len_wide", blen, 1 + 65*21);
        decode(2, 65);
        check("ovr_wide", ovr_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
